crc_ahb_ctrl: RTL
=================

Name: crc_ahb_ctrl

Overview:
- AHB-Lite slave register block in the fabric, behind the MSS fabric AHB master port (MSSH* bus).
- Sequences the CRC datapath engine: holds polynomial, seed and mode configuration, and pushes bus-written data words into the engine with a ready/valid handshake.
- Stalls the bus (HREADYOUT low) when the engine cannot accept data, or when a result is read before the engine is idle.

Parameters:
- ADDR_W, 5, width of HADDR decoded (register offsets 0x00-0x14)
- POLY_RST, 32'h04C11DB7, reset value of POLY register
- SEED_RST, 32'hFFFFFFFF, reset value of SEED register

Ports:
- HCLK  in  1  single clock (FAB_CLK domain)
- HRESET  in  1  synchronous reset, active-high
- HSEL  in  1  slave select
- HADDR  in  ADDR_W  byte address
- HTRANS  in  2  transfer type; bit1=1 means NONSEQ/SEQ
- HWRITE  in  1  1=write
- HSIZE  in  3  0=byte, 1=half, 2=word
- HWDATA  in  32  write data (data phase)
- HREADYIN  in  1  bus ready
- HREADYOUT  out  1  slave ready
- HRESP  out  1  always 0 (OKAY)
- HRDATA  out  32  read data
- crc_cfg  out  4  {xor_en, refout, refin, en} from CTRL
- crc_poly  out  32  POLY register
- crc_seed  out  32  SEED register
- crc_init  out  1  one-cycle pulse: engine loads crc_seed
- crc_valid  out  1  one-cycle data push
- crc_data  out  32  data word, valid with crc_valid
- crc_be  out  4  byte enables, valid with crc_valid
- crc_ready  in  1  engine can accept data / is idle
- crc_result  in  32  current CRC value

Behaviour:
- Register map:
  - 0x00 CTRL RW: [3:0] cfg; [8] INIT, write-1 pulses crc_init, reads 0.
  - 0x04 POLY RW.
  - 0x08 SEED RW; any write also pulses crc_init.
  - 0x0C DATA WO, reads 0.
  - 0x10 RESULT RO.
  - 0x14 STATUS: [0] crc_ready (live); [1] ERR, sticky, write-1-clear.
  - Unmapped offsets read 0; writes to them are ignored.
- Address phase is captured when HSEL & HTRANS[1] & HREADYIN; address, write flag and size are registered. The data phase is the next cycle.
- Write timing: register writes take effect at the end of the data phase; the new value is visible on outputs the following cycle. The crc_init pulse occurs in the cycle after the data phase.
- DATA write with CTRL.en=1:
  - crc_data=HWDATA.
  - crc_be by size: byte -> one-hot at HADDR[1:0]; half -> 4'b0011 or 4'b1100 by HADDR[1]; word -> 4'b1111.
  - If crc_ready=1 in the data phase: crc_valid pulses the next cycle with zero wait states.
  - Otherwise: FSM enters WR_WAIT, HREADYOUT=0 and HWDATA is latched. The cycle crc_ready=1 is seen, crc_valid pulses and HREADYOUT returns to 1 the same cycle.
- DATA write with CTRL.en=0: no push, no stall, STATUS.ERR set.
- RESULT read:
  - crc_ready=1: HRDATA=crc_result with zero wait states.
  - crc_ready=0: FSM enters RD_WAIT, HREADYOUT=0 until crc_ready=1, then HRDATA=crc_result and HREADYOUT=1.
- FSM states: IDLE -> WR_WAIT or RD_WAIT as above; both return to IDLE when crc_ready=1. While in a WAIT state a new address phase cannot be accepted (HREADYIN is low on the bus).
- A crc_valid pulse in cycle N counts as engine-busy for RESULT reads starting in cycle N: RESULT read immediately after the last DATA write stalls at least 1 cycle unless crc_ready stays high.
- Simultaneous CTRL.INIT and SEED write in one transfer is impossible (different offsets). Back-to-back SEED then DATA: crc_init precedes crc_valid by at least 1 cycle.
- HRDATA is driven 0 when not in a read data phase.
- Reset values:
  - HREADYOUT=1, HRDATA=0, HRESP=0.
  - crc_valid=0, crc_init=0, crc_data=0, crc_be=0.
  - CTRL=0, POLY=POLY_RST, SEED=SEED_RST, ERR=0, FSM=IDLE.
- Reset mid-stall: the pending write is discarded (no crc_valid) and HREADYOUT=1 the cycle after HRESET.

Test Plan:
- Reset, then read 0x04, 0x08, 0x00 -> 0x04C11DB7, 0xFFFFFFFF, 0x0; HREADYOUT=1 throughout.
- Write CTRL=0x1, write SEED=0x0 -> crc_init single pulse 1 cycle after the SEED data phase; crc_seed=0.
- crc_ready=1, word write 0x12345678 to DATA -> crc_valid for 1 cycle, crc_data=0x12345678, crc_be=4'hF, no wait states. Byte write at HADDR=0x0E -> crc_be=4'b0100.
- crc_ready held 0 for 5 cycles during a DATA write -> HREADYOUT low 5 cycles; crc_valid on the first crc_ready=1 cycle. RESULT read with crc_ready=0 for 3 cycles -> 3 wait states, then HRDATA=crc_result.
- CTRL.en=0, DATA write -> no crc_valid, STATUS reads 0x3 (ready=1, ERR=1); write 0x2 to STATUS -> reads 0x1.
- Assert HRESET during a WR_WAIT stall -> HREADYOUT=1 next cycle, no crc_valid ever, registers at reset values.

Source files
------------

// File: rtl/crc_ahb_ctrl.sv
// crc_ahb_ctrl: AHB-Lite register front-end for the CRC datapath engine.
// Holds polynomial/seed/mode configuration, pushes DATA writes into the
// engine over a ready/valid handshake and stalls the bus when the engine
// is busy on a DATA write or a RESULT read.
module crc_ahb_ctrl #(
    parameter int unsigned ADDR_W   = 5,
    parameter logic [31:0] POLY_RST = 32'h04C11DB7,
    parameter logic [31:0] SEED_RST = 32'hFFFFFFFF
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADYIN,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [31:0]       HRDATA,
    output logic [3:0]        crc_cfg,
    output logic [31:0]       crc_poly,
    output logic [31:0]       crc_seed,
    output logic              crc_init,
    output logic              crc_valid,
    output logic [31:0]       crc_data,
    output logic [3:0]        crc_be,
    input  logic              crc_ready,
    input  logic [31:0]       crc_result
);

    localparam int unsigned IW = ADDR_W - 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR_WAIT,
        S_RD_WAIT
    } state_t;

    state_t state_q, state_d;

    // Registered address phase
    logic              dph_q;
    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [1:0]        size_q;

    // Configuration and engine-side registers
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] poly_q, poly_d;
    logic [31:0] seed_q, seed_d;
    logic        err_q, err_d;
    logic        init_q, init_d;
    logic        push_q, push_d;
    logic [31:0] data_q, data_d;
    logic [3:0]  be_q, be_d;

    // Decode
    logic          addr_acc;
    logic [IW-1:0] widx;
    logic          sel_ctrl, sel_poly, sel_seed, sel_data, sel_result, sel_status;
    logic [3:0]    be_dph;
    logic          wr_dph, rd_dph;
    logic          push_ok, wr_stall, rd_stall;
    logic          valid_now;

    logic unused_htrans0;
    assign unused_htrans0 = HTRANS[0];

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int unsigned i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    // Address decode, byte lanes and handshake conditions for the current data phase
    always_comb begin
        addr_acc   = HSEL & HTRANS[1] & HREADYIN;
        widx       = addr_q[ADDR_W-1:2];
        sel_ctrl   = (widx == IW'(0));
        sel_poly   = (widx == IW'(1));
        sel_seed   = (widx == IW'(2));
        sel_data   = (widx == IW'(3));
        sel_result = (widx == IW'(4));
        sel_status = (widx == IW'(5));

        case (size_q)
            2'd0:    be_dph = 4'b0001 << addr_q[1:0];
            2'd1:    be_dph = addr_q[1] ? 4'b1100 : 4'b0011;
            default: be_dph = 4'b1111;
        endcase

        // Data phases are only ever live in IDLE; a WAIT state owns the
        // transfer once it has been stalled.
        wr_dph = dph_q & write_q & (state_q == S_IDLE);
        rd_dph = dph_q & ~write_q & (state_q == S_IDLE);

        // Push completing out of WR_WAIT is combinational so HREADYOUT and
        // crc_valid rise in the same cycle crc_ready is seen.
        valid_now = push_q | ((state_q == S_WR_WAIT) & crc_ready & ~HRESET);

        push_ok  = wr_dph & sel_data & ctrl_q[0];
        wr_stall = push_ok & ~crc_ready;
        // A push presented this cycle means the engine has not yet absorbed
        // the last word, so the result is not final.
        rd_stall = rd_dph & sel_result & ~(crc_ready & ~valid_now);
    end

    // Next values for the configuration and engine-side registers
    always_comb begin
        ctrl_d = ctrl_q;
        poly_d = poly_q;
        seed_d = seed_q;
        err_d  = err_q;
        data_d = data_q;
        be_d   = be_q;
        init_d = wr_dph & ((sel_ctrl & be_dph[1] & HWDATA[8]) | sel_seed);
        push_d = push_ok & crc_ready;

        if (push_ok) begin
            data_d = HWDATA;
            be_d   = be_dph;
        end
        if (wr_dph & sel_ctrl & be_dph[0]) ctrl_d = HWDATA[3:0];
        if (wr_dph & sel_poly) poly_d = merge_lanes(poly_q, HWDATA, be_dph);
        if (wr_dph & sel_seed) seed_d = merge_lanes(seed_q, HWDATA, be_dph);
        if (wr_dph & sel_data & ~ctrl_q[0]) begin
            err_d = 1'b1;
        end else if (wr_dph & sel_status & be_dph[0] & HWDATA[1]) begin
            err_d = 1'b0;
        end
    end

    // Address-phase capture and register state
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dph_q   <= 1'b0;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 2'd0;
            ctrl_q  <= '0;
            poly_q  <= POLY_RST;
            seed_q  <= SEED_RST;
            err_q   <= 1'b0;
            init_q  <= 1'b0;
            push_q  <= 1'b0;
            data_q  <= '0;
            be_q    <= '0;
        end else begin
            dph_q <= addr_acc;
            if (addr_acc) begin
                addr_q  <= HADDR;
                write_q <= HWRITE;
                size_q  <= HSIZE[2] ? 2'd2 : HSIZE[1:0];
            end
            ctrl_q <= ctrl_d;
            poly_q <= poly_d;
            seed_q <= seed_d;
            err_q  <= err_d;
            init_q <= init_d;
            push_q <= push_d;
            data_q <= data_d;
            be_q   <= be_d;
        end
    end

    // FSM state register
    always_ff @(posedge HCLK) begin
        if (HRESET) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state: enter a WAIT state on a stalled data phase, leave on crc_ready
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (wr_stall)      state_d = S_WR_WAIT;
                else if (rd_stall) state_d = S_RD_WAIT;
            end
            S_WR_WAIT: if (crc_ready) state_d = S_IDLE;
            S_RD_WAIT: if (crc_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // FSM outputs: bus ready, read data mux and engine-side signals
    always_comb begin
        HRESP     = 1'b0;
        HREADYOUT = 1'b1;
        HRDATA    = '0;
        case (state_q)
            S_IDLE:    HREADYOUT = ~(wr_stall | rd_stall);
            S_WR_WAIT: HREADYOUT = crc_ready;
            S_RD_WAIT: begin
                HREADYOUT = crc_ready;
                HRDATA    = crc_result;
            end
            default:   HREADYOUT = 1'b1;
        endcase

        if (rd_dph) begin
            if (sel_ctrl)        HRDATA = {28'd0, ctrl_q};
            else if (sel_poly)   HRDATA = poly_q;
            else if (sel_seed)   HRDATA = seed_q;
            else if (sel_result) HRDATA = crc_result;
            else if (sel_status) HRDATA = {30'd0, err_q, crc_ready};
            else                 HRDATA = '0;
        end

        crc_cfg   = ctrl_q;
        crc_poly  = poly_q;
        crc_seed  = seed_q;
        crc_init  = init_q;
        crc_valid = valid_now;
        crc_data  = data_q;
        crc_be    = be_q;
    end

endmodule
